// File: rtl/multicycle_control_pkg.sv
// Shared opcodes, state encoding and datapath select codes for the multicycle RV32I controller.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R    = 7'd51;
  localparam logic [6:0] OP_I    = 7'd19;
  localparam logic [6:0] OP_LW   = 7'd3;
  localparam logic [6:0] OP_SW   = 7'd35;
  localparam logic [6:0] OP_B    = 7'd99;
  localparam logic [6:0] OP_JAL  = 7'd111;
  localparam logic [6:0] OP_JALR = 7'd103;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_JALR2    = 4'd11,
    S_BEQ      = 4'd12,
    S_ILLEGAL  = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // R-type and unknown opcodes have no immediate; I format is a harmless default.
  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    logic [1:0] sel;
    sel = IMM_I;
    case (op)
      OP_SW:   sel = IMM_S;
      OP_B:    sel = IMM_B;
      OP_JAL:  sel = IMM_J;
      default: sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts not-ready cycles in a memory wait state and flags the last allowed cycle.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_count,
  output logic o_expire
);

  localparam int W       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int LIMIT_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [W-1:0] LIMIT = W'(LIMIT_I);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else if (i_count && (TIMEOUT > 0)) begin
      r_count <= r_count + W'(1);
    end
  end

  // Expire marks the TIMEOUT-th not-ready cycle, so the FSM can still honour a late ready.
  assign o_expire = (TIMEOUT > 0) && (r_count == LIMIT);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I main controller: sequences fetch/decode/execute/memory/writeback control
// with a memory ready handshake, wait timeout and illegal-opcode trap.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT = 1,
  parameter int TIMEOUT  = 16,
  parameter int TRAP_EN  = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [6:0] i_op,
  input  logic       i_zero,
  input  logic       i_mem_ready,
  output logic       o_pc_en,
  output logic       o_ir_write,
  output logic       o_adr_src,
  output logic       o_mem_write,
  output logic       o_reg_write,
  output logic       o_link,
  output logic [1:0] o_result_src,
  output logic [1:0] o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_imm_src,
  output logic       o_illegal,
  output logic       o_trap
);

  state_t r_state;
  state_t w_next;
  logic   r_from_jump;
  logic   w_ready;
  logic   w_in_wait;
  logic   w_expire;
  logic   w_pc_write;
  logic   w_branch;

  assign w_ready   = (MEM_WAIT != 0) ? i_mem_ready : 1'b1;
  assign w_in_wait = (r_state == S_FETCH) || (r_state == S_MEMREAD) || (r_state == S_MEMWRITE);

  // Any state change restarts the wait count, so every wait state is entered at zero.
  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_next != r_state),
    .i_count  (w_in_wait && !w_ready),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_FETCH;
      r_from_jump <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_from_jump <= (r_state == S_JAL) || (r_state == S_JALR2);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_ready)       w_next = S_DECODE;
        else if (w_expire) w_next = S_TRAP;
      end
      S_DECODE: begin
        case (i_op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_JAL:       w_next = S_JAL;
          OP_JALR:      w_next = S_JALR;
          OP_B:         w_next = S_BEQ;
          default:      w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:  w_next = (i_op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (w_ready)       w_next = S_MEMWB;
        else if (w_expire) w_next = S_TRAP;
      end
      S_MEMWB:   w_next = S_FETCH;
      S_MEMWRITE: begin
        if (w_ready)       w_next = S_FETCH;
        else if (w_expire) w_next = S_TRAP;
      end
      S_EXECR:   w_next = S_ALUWB;
      S_EXECI:   w_next = S_ALUWB;
      S_ALUWB:   w_next = S_FETCH;
      S_JAL:     w_next = S_ALUWB;
      S_JALR:    w_next = S_JALR2;
      S_JALR2:   w_next = S_ALUWB;
      S_BEQ:     w_next = S_FETCH;
      S_ILLEGAL: w_next = (TRAP_EN != 0) ? S_TRAP : S_FETCH;
      S_TRAP:    w_next = S_TRAP;
      default:   w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_branch     = 1'b0;
    o_ir_write   = 1'b0;
    o_adr_src    = 1'b0;
    o_mem_write  = 1'b0;
    o_reg_write  = 1'b0;
    o_link       = 1'b0;
    o_result_src = RES_ALUOUT;
    o_alu_src_a  = SRCA_PC;
    o_alu_src_b  = SRCB_RS2;
    o_alu_op     = ALUOP_ADD;
    o_illegal    = 1'b0;
    o_trap       = 1'b0;
    case (r_state)
      S_FETCH: begin
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        o_ir_write   = w_ready;
        w_pc_write   = w_ready;
      end
      S_DECODE: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: o_adr_src = 1'b1;
      S_MEMWB: begin
        o_result_src = RES_MEMDATA;
        o_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        o_adr_src   = 1'b1;
        o_mem_write = 1'b1;
      end
      S_EXECR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
        o_alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        o_reg_write = 1'b1;
        o_link      = r_from_jump;
      end
      S_JAL: begin
        o_alu_src_a = SRCA_OLDPC;
        o_alu_src_b = SRCB_FOUR;
        w_pc_write  = 1'b1;
        o_link      = 1'b1;
      end
      S_JALR: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_src_b = SRCB_IMM;
      end
      S_JALR2: begin
        o_alu_src_a  = SRCA_OLDPC;
        o_alu_src_b  = SRCB_FOUR;
        o_result_src = RES_ALURESULT;
        w_pc_write   = 1'b1;
        o_link       = 1'b1;
      end
      S_BEQ: begin
        o_alu_src_a = SRCA_RS1;
        o_alu_op    = ALUOP_SUB;
        w_branch    = 1'b1;
      end
      S_ILLEGAL: o_illegal = 1'b1;
      S_TRAP:    o_trap    = 1'b1;
      default: ;
    endcase
    // Reset abandons whatever is in flight: nothing may be written during the reset cycle.
    if (i_rst) begin
      w_pc_write   = 1'b0;
      w_branch     = 1'b0;
      o_ir_write   = 1'b0;
      o_adr_src    = 1'b0;
      o_mem_write  = 1'b0;
      o_reg_write  = 1'b0;
      o_link       = 1'b0;
      o_result_src = 2'b00;
      o_alu_src_a  = 2'b00;
      o_alu_src_b  = 2'b00;
      o_alu_op     = 2'b00;
      o_illegal    = 1'b0;
      o_trap       = 1'b0;
    end
  end

  assign o_pc_en   = w_pc_write | (w_branch & i_zero);
  assign o_imm_src = imm_src_of(i_op);

endmodule
